// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature decoder.
// Phase codes are {A,B}; the up (CW) order is PH0 -> PH1 -> PH2 -> PH3 -> PH0.
package qdec_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  localparam int INIT_CYCLES = 3;

  function automatic logic [1:0] phase_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Per-channel 2-flop synchronizer and stability filter; filt_o changes only after
// FILT_CYCLES consecutive disagreeing cycles. prime_i copies the synchronized level straight through.
module qdec_filter #(
  parameter int FILT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  input  logic prime_i,
  output logic sync_o,
  output logic filt_o
);

  localparam logic [7:0] CNT_MAX = 8'(FILT_CYCLES - 1);

  logic       s1_q, s2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (prime_i) begin
      filt_d = s2_q;
    end else if (s2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = s2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B -> step pulses, wrapping position, rotating one-hot LED.
// Optional index input enc_z (macro QDEC_INDEX_EN) zeroes the position on a rising edge at phase 00.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             err_clr,
`ifdef QDEC_INDEX_EN
  input  logic             enc_z,
`endif
  output logic             step_valid,
  output logic             step_dir,
  output logic [CNT_W-1:0] position,
  output logic [3:0]       led_onehot,
  output logic             err
);

  state_t           state_q, state_d;
  logic [1:0]       init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_vld_q, step_vld_d;
  logic             step_dir_q, step_dir_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [3:0]       led_q, led_d;
  logic             err_q, err_d;

  logic       prime;
  logic       sync_a, sync_b, filt_a, filt_b;
  logic [1:0] cur;

  assign prime = (state_q == INIT);
  assign cur   = {filt_a, filt_b};

  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .din_i(enc_a), .prime_i(prime), .sync_o(sync_a), .filt_o(filt_a)
  );

  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .din_i(enc_b), .prime_i(prime), .sync_o(sync_b), .filt_o(filt_b)
  );

`ifdef QDEC_INDEX_EN
  logic sync_z, filt_z;
  logic z_prev_q, z_prev_d;

  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_z (
    .clk(clk), .rst_n(rst_n), .din_i(enc_z), .prime_i(prime), .sync_o(sync_z), .filt_o(filt_z)
  );
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_vld_d = 1'b0;
    step_dir_d = 1'b0;
    pos_d      = pos_q;
    err_d      = err_clr ? 1'b0 : err_q;
`ifdef QDEC_INDEX_EN
    z_prev_d   = z_prev_q;
`endif
    case (state_q)
      INIT: begin
        // prev tracks the value the filters are about to load, so RUN starts with cur == prev.
        prev_d     = {sync_a, sync_b};
        init_cnt_d = init_cnt_q + 2'd1;
`ifdef QDEC_INDEX_EN
        z_prev_d   = sync_z;
`endif
        if (init_cnt_q == 2'(INIT_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      default: begin
        prev_d = cur;
        if (cur != prev_q) begin
          if (cur == phase_up(prev_q)) begin
            step_vld_d = 1'b1;
            step_dir_d = 1'b1;
            pos_d      = pos_q + CNT_W'(1);
          end else if (prev_q == phase_up(cur)) begin
            step_vld_d = 1'b1;
            pos_d      = pos_q - CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef QDEC_INDEX_EN
        z_prev_d = filt_z;
        if (filt_z && !z_prev_q && (cur == PH0)) begin
          pos_d = '0;
        end
`endif
      end
    endcase
    led_d = 4'b0001 << pos_d[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      prev_q     <= '0;
      step_vld_q <= 1'b0;
      step_dir_q <= 1'b0;
      pos_q      <= '0;
      led_q      <= 4'b0001;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_vld_q <= step_vld_d;
      step_dir_q <= step_dir_d;
      pos_q      <= pos_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

`ifdef QDEC_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_prev_q <= 1'b0;
    end else begin
      z_prev_q <= z_prev_d;
    end
  end
`endif

  assign step_valid = step_vld_q;
  assign step_dir   = step_dir_q;
  assign position   = pos_q;
  assign led_onehot = led_q;
  assign err        = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (FILT_CYCLES=4, CNT_W=8); expected steps are queued by the
// stimulus and matched by a negedge monitor. Index tests run only when QDEC_INDEX_EN is defined.
module tb_quad_decoder;

  localparam int FILT = 4;
  localparam int LAT  = FILT + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
  logic       enc_z = 1'b0;
`endif
  logic       step_valid;
  logic       step_dir;
  logic [7:0] position;
  logic [3:0] led_onehot;
  logic       err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dir;
    logic [7:0] pos;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  quad_decoder #(.FILT_CYCLES(FILT), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .err_clr(err_clr),
`ifdef QDEC_INDEX_EN
    .enc_z(enc_z),
`endif
    .step_valid(step_valid),
    .step_dir(step_dir),
    .position(position),
    .led_onehot(led_onehot),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] led_of(input logic [7:0] pos);
    logic [3:0] one;
    one = 4'b0001;
    return one << pos[1:0];
  endfunction

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && step_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("step_dir", step_dir, e.dir);
        chk("step_pos", position, e.pos);
        chk("step_led", led_onehot, led_of(e.pos));
        chk("step_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(posedge clk); #1;
    rst_n = 1'b0;
    enc_a = a;
    enc_b = b;
    wait_cycles(3);
    chk("rst_step_valid", step_valid, 1'b0);
    chk("rst_position", position, 8'd0);
    chk("rst_led", led_onehot, 4'b0001);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    wait_cycles(12);
  endtask

  // Drive a new {A,B} level; if a step is expected, queue it with its arrival cycle.
  task automatic apply(input logic a, input logic b, input logic vld, input logic dir,
                       input logic [7:0] pos);
    exp_t e;
    @(posedge clk); #1;
    enc_a = a;
    enc_b = b;
    if (vld) begin
      e.dir = dir;
      e.pos = pos;
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    wait_cycles(20);
  endtask

  initial begin
    // Pins high through reset: no spurious step or error after INIT.
    do_reset(1'b1, 1'b1);
    wait_cycles(50);
    chk("t1_err", err, 1'b0);
    chk("t1_position", position, 8'd0);
    chk("t1_led", led_onehot, 4'b0001);

    // One full up cycle.
    do_reset(1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'd2);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    chk("t2_position", position, 8'd4);
    chk("t2_led", led_onehot, 4'b0001);

    // Down through zero wraps, then back up wraps again.
    do_reset(1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 8'd255);
    chk("t3_position", position, 8'd255);
    chk("t3_led", led_onehot, 4'b1000);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 8'd254);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'd255);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("t3_wrap_up", position, 8'd0);

    // A 3-cycle glitch is shorter than the filter window.
    @(posedge clk); #1;
    enc_a = 1'b1;
    wait_cycles(3);
    enc_a = 1'b0;
    wait_cycles(20);
    chk("t4_position", position, 8'd0);
    chk("t4_err", err, 1'b0);

    // Illegal double change, clear, then set and clear together.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("t5_err_set", err, 1'b1);
    chk("t5_position", position, 8'd0);
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    wait_cycles(2);
    chk("t5_err_clr", err, 1'b0);
    @(posedge clk); #1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    wait_cycles(LAT - 1);
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    chk("t5_set_wins", err, 1'b1);
    wait_cycles(10);
    chk("t5_position2", position, 8'd0);

`ifdef QDEC_INDEX_EN
    // Start at phase 10 so seven up steps land on phase 00 with position 7.
    do_reset(1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'd4);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'd6);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'd7);
    chk("t6_pre_position", position, 8'd7);
    enc_z = 1'b1;
    wait_cycles(20);
    chk("t6_index_pos", position, 8'd0);
    chk("t6_index_led", led_onehot, 4'b0001);
    enc_z = 1'b0;
    wait_cycles(20);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'd2);
    enc_z = 1'b1;
    wait_cycles(20);
    chk("t6_index_ignored", position, 8'd2);
    enc_z = 1'b0;
    wait_cycles(20);
`endif

    wait_cycles(5);
    chk("pending_steps", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
